// File: rtl/fifo_wr_ingress.sv
// fifo_wr_ingress: write-domain front end of the asynchronous FIFO.
//
// The block sits directly in front of the write-pointer handler. It has four jobs:
//   - Accept a valid/ready stream and buffer it in a 2-entry in-order skid buffer.
//   - Issue wr_en/wr_data to the handler and RAM, held off while full is set.
//   - Bring the Gray read pointer into wr_clk through a 2-flop synchroniser.
//   - Register the write-side fill level and the almost-full flag.
//
// Ports:
//   wr_clk, rst     write clock; asynchronous active-high reset
//   s_valid/s_data  producer stream in
//   s_ready         high while the skid buffer has a free entry
//   g_rd_ptr        Gray read pointer from rd_clk (asynchronous)
//   g_rd_ptr_sync   synchronised Gray read pointer, to the handler
//   b_wr_ptr        binary write pointer from the handler
//   full            registered full flag from the handler
//   wr_en/wr_data   write request and RAM data (head of the skid buffer)
//   wr_level        registered occupancy, 0..2^ptr_width
//   almost_full     registered, wr_level >= af_thresh
module fifo_wr_ingress #(
    parameter int unsigned ptr_width  = 4,
    parameter int unsigned data_width = 8,
    parameter int unsigned af_thresh  = 12
) (
    input  logic                  wr_clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [data_width-1:0] s_data,
    output logic                  s_ready,
    input  logic [ptr_width:0]    g_rd_ptr,
    output logic [ptr_width:0]    g_rd_ptr_sync,
    input  logic [ptr_width:0]    b_wr_ptr,
    input  logic                  full,
    output logic                  wr_en,
    output logic [data_width-1:0] wr_data,
    output logic [ptr_width:0]    wr_level,
    output logic                  almost_full
);

    // ------------------------------------------------------------------
    // Read-pointer synchroniser: two plain flops, nothing in between.
    // ------------------------------------------------------------------
    logic [ptr_width:0] sync1_q;
    logic [ptr_width:0] sync2_q;

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= g_rd_ptr;
            sync2_q <= sync1_q;
        end
    end

    assign g_rd_ptr_sync = sync2_q;

    // Gray to binary: each bit is the XOR of all Gray bits at or above it.
    logic [ptr_width:0] b_rd_sync;

    always_comb begin
        b_rd_sync            = '0;
        b_rd_sync[ptr_width] = sync2_q[ptr_width];
        for (int i = int'(ptr_width) - 1; i >= 0; i--) begin
            b_rd_sync[i] = b_rd_sync[i+1] ^ sync2_q[i];
        end
    end

    // ------------------------------------------------------------------
    // Fill level and almost-full. Modulo-2^(ptr_width+1) subtraction
    // absorbs pointer wrap.
    // ------------------------------------------------------------------
    logic [ptr_width:0] level_d;
    logic [ptr_width:0] level_q;
    logic               af_d;
    logic               af_q;

    assign level_d = b_wr_ptr - b_rd_sync;
    assign af_d    = 32'(level_d) >= af_thresh;

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
            af_q    <= 1'b0;
        end else begin
            level_q <= level_d;
            af_q    <= af_d;
        end
    end

    assign wr_level    = level_q;
    assign almost_full = af_q;

    // ------------------------------------------------------------------
    // Skid buffer: ent0 is always the head, ent1 the second entry.
    // ------------------------------------------------------------------
    logic [1:0]            count_q, count_d;
    logic [data_width-1:0] ent0_q, ent0_d;
    logic [data_width-1:0] ent1_q, ent1_d;
    logic                  push;
    logic                  pop;

    // Both handshakes depend only on registered state, so there is no
    // combinational path from s_valid to s_ready or from full to s_ready.
    assign s_ready = (count_q != 2'd2);
    assign wr_en   = (count_q != 2'd0) && !full;
    assign wr_data = ent0_q;
    assign push    = s_valid && s_ready;
    assign pop     = wr_en;

    always_comb begin
        count_d = count_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        unique case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    ent0_d = s_data;
                end else begin
                    ent1_d = s_data;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                ent0_d  = ent1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Push implies count < 2, so the head is replaced by the
                // incoming word when only one entry is held.
                if (count_q == 2'd2) begin
                    ent0_d = ent1_q;
                    ent1_d = s_data;
                end else begin
                    ent0_d = s_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
            ent0_q  <= '0;
            ent1_q  <= '0;
        end else begin
            count_q <= count_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
        end
    end

endmodule
